// File: rtl/alert_rx_bank.sv
// Bank of independent differential alert receivers. Each channel synchronises
// its alert rails, runs the handshake FSM, checks rail integrity and drives
// the differential ping and acknowledge back to the sender.
`timescale 1ns/1ps

module alert_rx_bank #(
  parameter int unsigned NumAlerts  = 4,
  parameter int unsigned SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumAlerts-1:0] alert_p_i,
  input  logic [NumAlerts-1:0] alert_n_i,
  output logic [NumAlerts-1:0] ack_p_o,
  output logic [NumAlerts-1:0] ack_n_o,
  output logic [NumAlerts-1:0] ping_p_o,
  output logic [NumAlerts-1:0] ping_n_o,
  input  logic [NumAlerts-1:0] ping_req_i,
  output logic [NumAlerts-1:0] alert_o,
  output logic [NumAlerts-1:0] ping_ok_o,
  output logic [NumAlerts-1:0] integ_fail_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HS1  = 2'b01,
    HS2  = 2'b10
  } state_e;

  for (genvar k = 0; k < NumAlerts; k++) begin : g_chan
    logic [SyncStages-1:0] sync_p_q;
    logic [SyncStages-1:0] sync_n_q;
    logic                  sp;
    logic                  sn;
    state_e                state_q;
    state_e                state_d;
    logic                  pend_q;
    logic                  pend_d;
    logic                  hs_start;
    logic                  ping_acc;
    logic                  alert_d;
    logic                  ping_ok_d;
    logic                  alert_q;
    logic                  ping_ok_q;
    logic                  integ_q;
    logic                  ack_p_q;
    logic                  ack_n_q;
    logic                  ping_p_q;
    logic                  ping_n_q;

    // Multi-stage synchroniser on both alert rails
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_p_q <= '0;
        sync_n_q <= '0;
      end else begin
        sync_p_q <= {sync_p_q[SyncStages-2:0], alert_p_i[k]};
        sync_n_q <= {sync_n_q[SyncStages-2:0], alert_n_i[k]};
      end
    end

    assign sp = sync_p_q[SyncStages-1];
    assign sn = sync_n_q[SyncStages-1];

    // Handshake next-state, ping bookkeeping and pulse classification
    always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      hs_start  = 1'b0;
      alert_d   = 1'b0;
      ping_ok_d = 1'b0;
      ping_acc  = ping_req_i[k] & ~pend_q;
      case (state_q)
        IDLE: begin
          if (sp && !sn) begin
            state_d  = HS1;
            hs_start = 1'b1;
          end
        end
        HS1: begin
          if (sp == sn) begin
            state_d = IDLE;
          end else if (!sp && sn) begin
            state_d = HS2;
          end
        end
        HS2:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
      // Classification uses the flag as it was before this cycle's ping request
      alert_d   = hs_start & ~pend_q;
      ping_ok_d = hs_start & pend_q;
      if (ping_ok_d) begin
        pend_d = 1'b0;
      end else if (ping_acc) begin
        pend_d = 1'b1;
      end
    end

    // State, pending flag and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= IDLE;
        pend_q    <= 1'b0;
        alert_q   <= 1'b0;
        ping_ok_q <= 1'b0;
        integ_q   <= 1'b0;
        ack_p_q   <= 1'b0;
        ack_n_q   <= 1'b1;
        ping_p_q  <= 1'b0;
        ping_n_q  <= 1'b1;
      end else begin
        state_q   <= state_d;
        pend_q    <= pend_d;
        alert_q   <= alert_d;
        ping_ok_q <= ping_ok_d;
        integ_q   <= (sp == sn);
        ack_p_q   <= (state_d == HS1);
        ack_n_q   <= (state_d != HS1);
        ping_p_q  <= ping_p_q ^ ping_acc;
        ping_n_q  <= ping_n_q ^ ping_acc;
      end
    end

    assign alert_o[k]      = alert_q;
    assign ping_ok_o[k]    = ping_ok_q;
    assign integ_fail_o[k] = integ_q;
    assign ack_p_o[k]      = ack_p_q;
    assign ack_n_o[k]      = ack_n_q;
    assign ping_p_o[k]     = ping_p_q;
    assign ping_n_o[k]     = ping_n_q;
  end

endmodule

// File: tb/tb_alert_rx_bank.sv
// Directed bench for alert_rx_bank (4 channels, 2 sync stages): a vector
// table for the basic alert handshake plus hand-written multi-cycle sequences.
`timescale 1ns/1ps

module tb_alert_rx_bank;

  localparam int unsigned N = 4;

  logic         clk_i  = 1'b0;
  logic         rst_ni = 1'b1;
  logic [N-1:0] alert_p_i;
  logic [N-1:0] alert_n_i;
  logic [N-1:0] ping_req_i;
  logic [N-1:0] ack_p_o;
  logic [N-1:0] ack_n_o;
  logic [N-1:0] ping_p_o;
  logic [N-1:0] ping_n_o;
  logic [N-1:0] alert_o;
  logic [N-1:0] ping_ok_o;
  logic [N-1:0] integ_fail_o;

  int           total = 0;
  int           bad   = 0;
  logic [N-1:0] exp_ping;

  typedef struct {
    logic [N-1:0] ap;
    logic [N-1:0] an;
    logic [N-1:0] preq;
    logic [N-1:0] alert;
    logic [N-1:0] ping_ok;
    logic [N-1:0] ack;
    logic [N-1:0] integ;
  } vec_t;

  vec_t vecs[15];

  alert_rx_bank #(
    .NumAlerts (N),
    .SyncStages(2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .alert_p_i   (alert_p_i),
    .alert_n_i   (alert_n_i),
    .ack_p_o     (ack_p_o),
    .ack_n_o     (ack_n_o),
    .ping_p_o    (ping_p_o),
    .ping_n_o    (ping_n_o),
    .ping_req_i  (ping_req_i),
    .alert_o     (alert_o),
    .ping_ok_o   (ping_ok_o),
    .integ_fail_o(integ_fail_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] e_alert,
                           input logic [N-1:0] e_pok, input logic [N-1:0] e_ack,
                           input logic [N-1:0] e_integ);
    chk($sformatf("%s alert_o", tag), alert_o, e_alert);
    chk($sformatf("%s ping_ok_o", tag), ping_ok_o, e_pok);
    chk($sformatf("%s ack_p_o", tag), ack_p_o, e_ack);
    chk($sformatf("%s ack_n_o", tag), ack_n_o, ~e_ack);
    chk($sformatf("%s ping_p_o", tag), ping_p_o, exp_ping);
    chk($sformatf("%s ping_n_o", tag), ping_n_o, ~exp_ping);
    chk($sformatf("%s integ_fail_o", tag), integ_fail_o, e_integ);
  endtask

  task automatic drive(input logic [N-1:0] ap, input logic [N-1:0] an);
    alert_p_i = ap;
    alert_n_i = an;
  endtask

  initial begin
    // Channel 2 alert raised for 10 cycles, then released
    for (int i = 0; i < 15; i++) begin
      vecs[i].ap      = (i < 10) ? 4'b0100 : 4'b0000;
      vecs[i].an      = (i < 10) ? 4'b1011 : 4'b1111;
      vecs[i].preq    = 4'b0000;
      vecs[i].alert   = (i == 2) ? 4'b0100 : 4'b0000;
      vecs[i].ping_ok = 4'b0000;
      vecs[i].ack     = (i >= 2 && i <= 11) ? 4'b0100 : 4'b0000;
      vecs[i].integ   = 4'b0000;
    end

    drive(4'b0000, 4'b1111);
    ping_req_i = '0;
    exp_ping   = '0;

    // Asynchronous reset values
    #2 rst_ni = 1'b0;
    #1 check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();
    rst_ni = 1'b1;
    repeat (5) tick();
    check_all("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Vector table: alert handshake on channel 2
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ap, vecs[i].an);
      ping_req_i = vecs[i].preq;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].alert, vecs[i].ping_ok, vecs[i].ack, vecs[i].integ);
    end

    // Ping round trip on channel 0
    ping_req_i = 4'b0001;
    tick();
    ping_req_i = 4'b0000;
    exp_ping   = 4'b0001;
    check_all("ping req", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drive(4'b0001, 4'b1110);
    tick(); check_all("ping hs1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); check_all("ping hs2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); check_all("ping ok", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tick(); check_all("ping hold", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    drive(4'b0000, 4'b1111);
    tick(); check_all("ping rel1", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick(); check_all("ping rel2", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick(); check_all("ping rel3", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); check_all("ping rel4", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Integrity fault on channel 1: both rails high
    drive(4'b0010, 4'b1111);
    tick(); check_all("integ1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); check_all("integ2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); check_all("integ3", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tick(); check_all("integ4", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    // Valid alert from the faulted state enters HS1
    drive(4'b0010, 4'b1101);
    tick(); check_all("integ hs a", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tick(); check_all("integ hs b", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tick(); check_all("integ hs c", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    tick(); check_all("integ hs d", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    // Both rails low inside HS1 aborts the handshake
    drive(4'b0000, 4'b1101);
    tick(); check_all("abort a", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    tick(); check_all("abort b", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    tick(); check_all("abort c", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tick(); check_all("abort d", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    drive(4'b0000, 4'b1111);
    tick(); check_all("recov a", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tick(); check_all("recov b", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tick(); check_all("recov c", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); check_all("recov d", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Fresh alert proves the channel is back in IDLE
    drive(4'b0010, 4'b1101);
    tick(); tick();
    tick(); check_all("re-alert", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    drive(4'b0000, 4'b1111);
    tick(); tick();
    tick(); check_all("re-alert rel", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();

    // Ping request coinciding with channel 3's IDLE-to-HS1 sample
    drive(4'b1000, 4'b0111);
    tick(); check_all("simul a", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); check_all("simul b", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    ping_req_i = 4'b1000;
    tick();
    ping_req_i = 4'b0000;
    exp_ping   = 4'b1001;
    check_all("simul c", 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    tick(); check_all("simul d", 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    // Second request while pending is ignored
    ping_req_i = 4'b1000;
    tick();
    ping_req_i = 4'b0000;
    check_all("dup ping", 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    drive(4'b0000, 4'b1111);
    tick(); check_all("simul rel a", 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    tick(); check_all("simul rel b", 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    tick(); check_all("simul rel c", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    // Next handshake answers the pending ping
    drive(4'b1000, 4'b0111);
    tick(); tick();
    tick(); check_all("simul pok", 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    tick(); check_all("simul pok d", 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    drive(4'b0000, 4'b1111);
    tick(); tick();
    tick(); check_all("simul pok rel", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();

    // Reset while channel 0 is in HS1 with a ping pending
    drive(4'b0001, 4'b1110);
    tick(); tick();
    tick(); check_all("pre-rst hs", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    ping_req_i = 4'b0001;
    tick();
    ping_req_i = 4'b0000;
    exp_ping   = 4'b1000;
    check_all("pre-rst ping", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick(); check_all("pre-rst hold", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    #2 rst_ni = 1'b0;
    exp_ping = 4'b0000;
    #1 check_all("rst mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); tick();
    rst_ni = 1'b1;
    tick(); check_all("post rst a", 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    tick(); check_all("post rst b", 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    tick(); check_all("post rst alert", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    tick(); check_all("post rst hold", 4'b0000, 4'b0000, 4'b0001, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alert_rx_bank.md
ALERT_RX_BANK -- requirements
Module: alert_rx_bank

Interface
REQ-001 Parameter NumAlerts, default 4: number of independent differential alert receiver channels, legal range 1..32.
REQ-002 Parameter SyncStages, default 2: depth of the input synchroniser on each alert wire, legal range 2..4.
REQ-003 Port clk_i  input  1  the single clock; all flops are rising-edge on clk_i.
REQ-004 Port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 Port alert_p_i  input  NumAlerts  positive rail of each channel's differential alert from the sender.
REQ-006 Port alert_n_i  input  NumAlerts  negative rail of each channel's differential alert.
REQ-007 Port ack_p_o / ack_n_o  output  NumAlerts each  differential acknowledge back to the sender.
REQ-008 Port ping_p_o / ping_n_o  output  NumAlerts each  differential ping to the sender; the ping is signalled by toggling both rails.
REQ-009 Port ping_req_i  input  NumAlerts  one-cycle pulse requesting a ping on channel k.
REQ-010 Port alert_o  output  NumAlerts  one-cycle pulse marking a genuine alert on channel k.
REQ-011 Port ping_ok_o  output  NumAlerts  one-cycle pulse marking a completed ping on channel k.
REQ-012 Port integ_fail_o  output  NumAlerts  level signal, high while channel k's synchronised rails are equal.

Function
REQ-013 Each channel is independent and identical; every rule below is stated per channel k.
REQ-014 alert_p_i[k] and alert_n_i[k] each pass through SyncStages flops before any use; these values are "sp" and "sn".
REQ-015 integ_fail_o[k] is registered: it is high in the cycle after sp==sn is sampled and low in the cycle after sp!=sn is sampled.
REQ-016 The channel FSM has three states: IDLE, HS1 and HS2.
REQ-017 IDLE to HS1 when sp=1 and sn=0 are sampled; this transition produces exactly one of two pulses in the next cycle:
- ping_ok_o[k] if a ping is pending; the pending flag is then cleared;
- alert_o[k] otherwise.
REQ-018 HS1 to HS2 when sp=0 and sn=1 are sampled; otherwise the FSM stays in HS1 with no timeout.
REQ-019 HS2 to IDLE unconditionally after one cycle, which enforces a minimum gap between consecutive handshakes.
REQ-020 ack_p_o[k] is registered and equals 1 exactly while the state is HS1; ack_n_o[k] is always its complement.
REQ-021 If sp==sn is sampled in HS1, the FSM goes to IDLE, ack is deasserted, and no further alert_o or ping_ok_o pulse is produced.
REQ-022 In IDLE, sp==sn causes no transition.
REQ-023 ping_req_i[k] is accepted only when no ping is pending. On acceptance:
- ping_p_o[k] and ping_n_o[k] both toggle in the next cycle;
- the pending flag is set.
REQ-024 ping_req_i[k] while a ping is already pending is ignored: no toggle, and the flag is unchanged.
REQ-025 If ping_req_i[k] and the IDLE-to-HS1 condition occur in the same cycle:
- the handshake is classified as alert_o[k], because the pending flag was not yet set;
- the ping is still accepted and the flag is set.
REQ-026 ping_p_o[k] and ping_n_o[k] are always complementary.
REQ-027 Latency from the sender's alert_p/alert_n edge to the alert_o or ping_ok_o pulse is SyncStages+1 cycles.
REQ-028 Latency from the sender's alert_p/alert_n edge to the ack_p_o rise is SyncStages+1 cycles.

Reset
REQ-029 While rst_ni=0 the following values hold asynchronously; all state is restored to them:
- FSM state is IDLE, all synchroniser flops are 0, and the ping pending flag is 0;
- ack_p_o=0 and ack_n_o=all ones;
- ping_p_o=0 and ping_n_o=all ones;
- alert_o=0, ping_ok_o=0 and integ_fail_o=0.
REQ-030 If reset is asserted mid-handshake, the FSM returns to IDLE and ack drops immediately.
REQ-031 After reset release, a sender still holding alert_p=1 is treated as a new alert.

Verification
REQ-032 Alert handshake, NumAlerts=4, SyncStages=2: drive ch2 alert_p=1/alert_n=0 at cycle 0.
- Expected: alert_o=4'b0100 at cycle 3 and ack_p_o[2]=1 from cycle 3.
- Then release the alert at cycle 10. Expected: ack_p_o[2]=0 at cycle 13, and the FSM is in IDLE at cycle 14.
REQ-033 Ping round-trip: pulse ping_req_i[0].
- Expected: ping_p_o[0] goes 0->1 and ping_n_o[0] goes 1->0 in the next cycle.
- Then return the sender's alert handshake. Expected: ping_ok_o[0] pulses once and alert_o[0] stays 0.
REQ-034 Integrity: drive ch1 alert_p=alert_n=1.
- Expected: integ_fail_o[1]=1 three cycles later, with no alert_o pulse and no ack.
- Then drive alert_p=1/alert_n=0 in HS1 followed by alert_p=alert_n=0. Expected: ack drops and the FSM returns to IDLE.
REQ-035 Simultaneous event: ping_req_i[3] in the same cycle as ch3's IDLE-to-HS1 sample.
- Expected: alert_o[3] pulses, the ping toggles, and the next handshake yields ping_ok_o[3].
- Expected: a second ping_req_i[3] while the ping is pending causes no toggle.
REQ-036 Reset mid-operation: assert rst_ni=0 while ch0 is in HS1 with a ping pending.
- Expected immediately: ack_p_o=0, ping_p_o=0, ping_n_o=all ones, all pulses 0.
- Expected after release with the sender still holding alert_p=1: alert_o[0] pulses.
